// File: rtl/hc_request_arbiter_pkg.sv
// Shared request types for the HardCloud CCI-P request arbiter, plus the
// round-robin pick helper.
package hc_request_arbiter_pkg;

    localparam int HC_BUFFER_SIZE   = 2;
    localparam int HC_REQUEST_DEPTH = 8;

    typedef enum logic [1:0] {
        e_REQUEST_IDLE        = 2'd0,
        e_REQUEST_READ        = 2'd1,
        e_REQUEST_WRITE       = 2'd2,
        e_REQUEST_READ_STREAM = 2'd3
    } t_request_cmd;

    typedef logic [3:0]  t_request_cmd_id;
    typedef logic [15:0] t_request_offset;
    typedef logic [15:0] t_request_size;

    typedef struct packed {
        t_request_cmd    cmd;
        t_request_cmd_id id;
        t_request_offset offset;
    } t_request_control;

    typedef logic [$clog2(HC_REQUEST_DEPTH):0] t_request_count;

    typedef struct packed {
        logic           empty;
        logic           full;
        t_request_count count;
    } t_request_status;

    typedef logic [$clog2(HC_BUFFER_SIZE)-1:0] t_arb_ptr;

    // First set bit of valid at or after ptr, wrapping at n (n <= HC_BUFFER_SIZE).
    function automatic logic [HC_BUFFER_SIZE-1:0] hc_rr_pick(
        input logic [HC_BUFFER_SIZE-1:0] valid,
        input t_arb_ptr                  ptr,
        input int                        n
    );
        logic [HC_BUFFER_SIZE-1:0] onehot;
        logic                      found;
        int                        idx;
        t_arb_ptr                  sel;
        onehot = '0;
        found  = 1'b0;
        for (int k = 0; k < HC_BUFFER_SIZE; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            sel = t_arb_ptr'(idx);
            if (k < n && !found && valid[sel]) begin
                onehot[sel] = 1'b1;
                found       = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/hc_request_arbiter_if.sv
// Request/grant/response bundle between the buffer requesters, the arbiter
// and the CCI-P requestor FSMs.
interface hc_request_arbiter_if
    import hc_request_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = HC_BUFFER_SIZE
);

    logic                                enable;
    logic             [NUM_PORTS-1:0]    req_valid;
    t_request_control [NUM_PORTS-1:0]    req_control;
    logic             [NUM_PORTS-1:0]    req_ready;
    logic                                tx_almfull;
    logic                                grant_valid;
    t_request_control                    grant_control;
    logic                                rd_rsp_valid;
    t_request_cmd_id                     rd_rsp_id;
    logic                                wr_rsp_valid;
    t_request_cmd_id                     wr_rsp_id;
    t_request_status  [NUM_PORTS-1:0]    status;
    logic                                idle;
    logic                                err;

    modport master (
        output enable, req_valid, req_control, tx_almfull,
               rd_rsp_valid, rd_rsp_id, wr_rsp_valid, wr_rsp_id,
        input  req_ready, grant_valid, grant_control, status, idle, err
    );

    modport slave (
        input  enable, req_valid, req_control, tx_almfull,
               rd_rsp_valid, rd_rsp_id, wr_rsp_valid, wr_rsp_id,
        output req_ready, grant_valid, grant_control, status, idle, err
    );

endinterface

// File: rtl/hc_request_arbiter_outstanding_counter.sv
// Per-port outstanding-request counter: +1 per accepted request, -1 per
// completion, saturating at zero with a sticky underflow flag.
module hc_outstanding_counter
    import hc_request_arbiter_pkg::*;
#(
    parameter int DEPTH = HC_REQUEST_DEPTH
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            inc,
    input  logic            dec_rd,
    input  logic            dec_wr,
    output t_request_status status,
    output logic            underflow_err
);

    localparam int CW = $bits(t_request_count);

    t_request_count count_q;
    t_request_count count_d;
    logic [CW:0]    up;
    logic [CW:0]    dn;
    logic           underflow;
    logic           err_q;

    // The arbiter never accepts at DEPTH, so only the low side needs clamping.
    always_comb begin
        up        = {1'b0, count_q} + {{CW{1'b0}}, inc};
        dn        = {{CW{1'b0}}, dec_rd} + {{CW{1'b0}}, dec_wr};
        underflow = (dn > up);
        count_d   = underflow ? '0 : t_request_count'(up - dn);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_q | underflow;
        end
    end

    assign status.empty  = (count_q == '0);
    assign status.full   = (count_q == t_request_count'(DEPTH));
    assign status.count  = count_q;
    assign underflow_err = err_q;

endmodule

// File: rtl/hc_request_arbiter.sv
// Round-robin arbiter sharing the CCI-P request path between the HardCloud
// buffer requesters, with per-port outstanding-request tracking.
module hc_request_arbiter
    import hc_request_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = HC_BUFFER_SIZE,
    parameter int DEPTH     = HC_REQUEST_DEPTH
) (
    input logic                 clk,
    input logic                 reset_n,
    hc_request_arbiter_if.slave bus
);

    logic            [NUM_PORTS-1:0]      eligible;
    logic            [NUM_PORTS-1:0]      pick;
    logic            [NUM_PORTS-1:0]      rd_hit;
    logic            [NUM_PORTS-1:0]      wr_hit;
    logic            [NUM_PORTS-1:0]      cnt_err;
    logic            [NUM_PORTS-1:0]      port_empty;
    logic            [HC_BUFFER_SIZE-1:0] pick_full;
    t_request_status [NUM_PORTS-1:0]      st;

    t_arb_ptr         rr_ptr;
    t_arb_ptr         win_idx;
    logic             win_any;
    t_request_control win_control;
    logic             bad_id;

    logic             grant_valid_q;
    t_request_control grant_control_q;
    logic             bad_id_err_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign eligible[i] = bus.req_valid[i]
                           && (bus.req_control[i].cmd != e_REQUEST_IDLE)
                           && (st[i].count < t_request_count'(DEPTH))
                           && bus.enable
                           && !bus.tx_almfull;

        assign rd_hit[i] = bus.rd_rsp_valid && (bus.rd_rsp_id == t_request_cmd_id'(i));
        assign wr_hit[i] = bus.wr_rsp_valid && (bus.wr_rsp_id == t_request_cmd_id'(i));

        // Counts from the acceptance cycle, not the registered grant cycle.
        hc_outstanding_counter #(
            .DEPTH (DEPTH)
        ) u_cnt (
            .clk           (clk),
            .reset_n       (reset_n),
            .inc           (pick[i]),
            .dec_rd        (rd_hit[i]),
            .dec_wr        (wr_hit[i]),
            .status        (st[i]),
            .underflow_err (cnt_err[i])
        );

        assign port_empty[i] = st[i].empty;
    end

    assign pick_full = hc_rr_pick(HC_BUFFER_SIZE'(eligible), rr_ptr, NUM_PORTS);
    assign pick      = pick_full[NUM_PORTS-1:0];

    always_comb begin
        win_any = |pick;
        win_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick[i]) begin
                win_idx = t_arb_ptr'(i);
            end
        end
        win_control    = bus.req_control[win_idx];
        win_control.id = t_request_cmd_id'(win_idx);
    end

    // Completions tagged with a port that does not exist are dropped.
    assign bad_id = (bus.rd_rsp_valid && (bus.rd_rsp_id >= t_request_cmd_id'(NUM_PORTS)))
                 || (bus.wr_rsp_valid && (bus.wr_rsp_id >= t_request_cmd_id'(NUM_PORTS)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_valid_q   <= 1'b0;
            grant_control_q <= '0;
            rr_ptr          <= '0;
            bad_id_err_q    <= 1'b0;
        end else begin
            grant_valid_q <= win_any;
            if (win_any) begin
                grant_control_q <= win_control;
                rr_ptr          <= (win_idx == t_arb_ptr'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
            end
            bad_id_err_q <= bad_id_err_q | bad_id;
        end
    end

    assign bus.req_ready     = reset_n ? pick : '0;
    assign bus.grant_valid   = grant_valid_q;
    assign bus.grant_control = grant_control_q;
    assign bus.status        = st;
    assign bus.idle          = !bus.enable && (&port_empty);
    assign bus.err           = bad_id_err_q || (|cnt_err);

endmodule

// File: tb/tb_hc_request_arbiter.sv
// Bench for hc_request_arbiter: directed scenarios plus randomized traffic
// against a queue-free behavioural model of the arbitration rules.
module tb_hc_request_arbiter;
    import hc_request_arbiter_pkg::*;

    localparam int N     = HC_BUFFER_SIZE;
    localparam int DEPTH = HC_REQUEST_DEPTH;

    logic clk = 1'b0;
    logic reset_n;

    hc_request_arbiter_if #(.NUM_PORTS(N)) bus ();

    hc_request_arbiter #(.NUM_PORTS(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int               m_cnt [N];
    int               m_ptr;
    logic             m_gv;
    t_request_control m_gc;
    logic             m_err;

    function automatic int model_winner();
        int p;
        if (!reset_n || !bus.enable || bus.tx_almfull) return -1;
        for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (bus.req_valid[p] && bus.req_control[p].cmd != e_REQUEST_IDLE && m_cnt[p] < DEPTH)
                return p;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w;
        w = model_winner();
        if (w < 0) return '0;
        return N'(1 << w);
    endfunction

    function automatic t_request_status model_status(int p);
        t_request_status s;
        s.empty = (m_cnt[p] == 0);
        s.full  = (m_cnt[p] == DEPTH);
        s.count = t_request_count'(m_cnt[p]);
        return s;
    endfunction

    function automatic logic model_idle();
        logic all_zero;
        all_zero = 1'b1;
        for (int p = 0; p < N; p++) if (m_cnt[p] != 0) all_zero = 1'b0;
        return !bus.enable && all_zero;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < N; p++) m_cnt[p] = 0;
        m_ptr = 0;
        m_gv  = 1'b0;
        m_gc  = '0;
        m_err = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.enable       = 1'b0;
        bus.req_valid    = '0;
        bus.req_control  = '0;
        bus.tx_almfull   = 1'b0;
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_id    = '0;
        bus.wr_rsp_valid = 1'b0;
        bus.wr_rsp_id    = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic t_request_control mk_ctl(t_request_cmd c, int id, int off);
        t_request_control r;
        r.cmd    = c;
        r.id     = t_request_cmd_id'(id);
        r.offset = t_request_offset'(off);
        return r;
    endfunction

    // One clock: model advances on the edge from the inputs held across it.
    task automatic tick();
        int              w;
        int              net;
        logic            rv, wv;
        t_request_cmd_id ri, wi;
        w  = model_winner();
        rv = bus.rd_rsp_valid; ri = bus.rd_rsp_id;
        wv = bus.wr_rsp_valid; wi = bus.wr_rsp_id;
        @(posedge clk);
        if (w >= 0) begin
            m_gv    = 1'b1;
            m_gc    = bus.req_control[w];
            m_gc.id = t_request_cmd_id'(w);
            m_ptr   = (w + 1) % N;
        end else begin
            m_gv = 1'b0;
        end
        for (int p = 0; p < N; p++) begin
            net = m_cnt[p] + ((w == p) ? 1 : 0)
                - ((rv && int'(ri) == p) ? 1 : 0)
                - ((wv && int'(wi) == p) ? 1 : 0);
            if (net < 0) begin
                net   = 0;
                m_err = 1'b1;
            end
            m_cnt[p] = net;
        end
        if (rv && int'(ri) >= N) m_err = 1'b1;
        if (wv && int'(wi) >= N) m_err = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        t_request_status exp_s;
        exp_s = '{empty: 1'b1, full: 1'b0, count: '0};
        clear_inputs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        model_reset();
        bus.enable      = 1'b1;
        bus.req_valid   = '1;
        bus.req_control[0] = mk_ctl(e_REQUEST_READ, 0, 16'h1);
        bus.req_control[1] = mk_ctl(e_REQUEST_READ, 1, 16'h2);
        #1;
        total++;
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL ready_in_reset got=%b want=00", bus.req_ready); end
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int p = 0; p < N; p++) begin
            total++;
            if (bus.status[p] !== exp_s) begin bad++; $display("FAIL reset_status[%0d] got=%h want=%h", p, bus.status[p], exp_s); end
        end
        total++;
        if (bus.idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", bus.idle); end
        total++;
        if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL reset_grant_valid got=%b want=0", bus.grant_valid); end
        total++;
        if (bus.grant_control !== '0) begin bad++; $display("FAIL reset_grant_control got=%h want=0", bus.grant_control); end
        total++;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
    endtask

    task automatic test_round_robin();
        int exp_p;
        apply_reset();
        bus.enable         = 1'b1;
        bus.req_valid      = 2'b11;
        bus.req_control[0] = mk_ctl(e_REQUEST_READ_STREAM, 9, 16'h0010);
        bus.req_control[1] = mk_ctl(e_REQUEST_READ_STREAM, 5, 16'h0020);
        for (int k = 0; k < 4; k++) begin
            exp_p = k % 2;
            #1;
            total++;
            if (bus.req_ready !== N'(1 << exp_p)) begin bad++; $display("FAIL rr_ready[%0d] got=%b want port %0d", k, bus.req_ready, exp_p); end
            tick();
            total++;
            if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL rr_grant_valid[%0d] got=%b want=1", k, bus.grant_valid); end
            total++;
            if (bus.grant_control !== mk_ctl(e_REQUEST_READ_STREAM, exp_p, exp_p ? 16'h0020 : 16'h0010)) begin
                bad++; $display("FAIL rr_grant_control[%0d] got=%h want port %0d", k, bus.grant_control, exp_p);
            end
        end
        for (int p = 0; p < N; p++) begin
            total++;
            if (bus.status[p].count !== t_request_count'(2)) begin bad++; $display("FAIL rr_count[%0d] got=%0d want=2", p, bus.status[p].count); end
        end
    endtask

    task automatic test_depth_limit();
        int grants;
        grants = 0;
        apply_reset();
        bus.enable         = 1'b1;
        bus.req_valid      = 2'b01;
        bus.req_control[0] = mk_ctl(e_REQUEST_READ, 0, 16'h0040);
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            total++;
            if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL depth_ready[%0d] got=%b want=01", k, bus.req_ready); end
            tick();
            if (bus.grant_valid === 1'b1) grants++;
        end
        #1;
        total++;
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL depth_block got=%b want=00", bus.req_ready); end
        total++;
        if (bus.status[0] !== '{empty: 1'b0, full: 1'b1, count: t_request_count'(DEPTH)}) begin
            bad++; $display("FAIL depth_full_status got=%h want full count=%0d", bus.status[0], DEPTH);
        end
        tick();
        total++;
        if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL depth_no_grant got=%b want=0", bus.grant_valid); end
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_id    = 4'd0;
        #1;
        total++;
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL depth_rsp_cycle_ready got=%b want=00", bus.req_ready); end
        tick();
        bus.rd_rsp_valid = 1'b0;
        total++;
        if (bus.status[0].count !== t_request_count'(DEPTH - 1)) begin bad++; $display("FAIL depth_after_rsp got=%0d want=%0d", bus.status[0].count, DEPTH - 1); end
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL depth_reopen got=%b want=01", bus.req_ready); end
        tick();
        if (bus.grant_valid === 1'b1) grants++;
        total++;
        if (grants !== DEPTH + 1) begin bad++; $display("FAIL depth_grant_total got=%0d want=%0d", grants, DEPTH + 1); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.enable         = 1'b1;
        bus.req_valid      = 2'b11;
        bus.req_control[0] = mk_ctl(e_REQUEST_READ, 0, 16'h0100);
        bus.req_control[1] = mk_ctl(e_REQUEST_READ, 1, 16'h0200);
        tick();
        bus.tx_almfull = 1'b1;
        #1;
        total++;
        if (bus.grant_valid !== 1'b1 || bus.grant_control.id !== 4'd0) begin
            bad++; $display("FAIL bp_inflight got valid=%b id=%0d want valid=1 id=0", bus.grant_valid, bus.grant_control.id);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=00", k, bus.req_ready); end
            tick();
            total++;
            if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL bp_grant[%0d] got=%b want=0", k, bus.grant_valid); end
        end
        bus.tx_almfull = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL bp_resume_ready got=%b want=10", bus.req_ready); end
        tick();
        total++;
        if (bus.grant_valid !== 1'b1 || bus.grant_control.id !== 4'd1) begin
            bad++; $display("FAIL bp_resume_grant got valid=%b id=%0d want valid=1 id=1", bus.grant_valid, bus.grant_control.id);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        bus.enable         = 1'b1;
        bus.req_valid      = 2'b10;
        bus.req_control[1] = mk_ctl(e_REQUEST_WRITE, 1, 16'h0300);
        repeat (3) tick();
        total++;
        if (bus.status[1].count !== t_request_count'(3)) begin bad++; $display("FAIL sim_pre_count got=%0d want=3", bus.status[1].count); end
        bus.rd_rsp_valid = 1'b1; bus.rd_rsp_id = 4'd1;
        bus.wr_rsp_valid = 1'b1; bus.wr_rsp_id = 4'd1;
        #1;
        total++;
        if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL sim_ready got=%b want=10", bus.req_ready); end
        tick();
        bus.rd_rsp_valid = 1'b0;
        bus.wr_rsp_valid = 1'b0;
        total++;
        if (bus.status[1].count !== t_request_count'(2)) begin bad++; $display("FAIL sim_net_count got=%0d want=2", bus.status[1].count); end
        total++;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL sim_err got=%b want=0", bus.err); end
    endtask

    task automatic test_errors_stop();
        apply_reset();
        bus.enable       = 1'b1;
        bus.wr_rsp_valid = 1'b1;
        bus.wr_rsp_id    = 4'd0;
        tick();
        bus.wr_rsp_valid = 1'b0;
        total++;
        if (bus.status[0].count !== '0 || bus.err !== 1'b1) begin
            bad++; $display("FAIL underflow got count=%0d err=%b want count=0 err=1", bus.status[0].count, bus.err);
        end
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_id    = 4'd3;
        tick();
        bus.rd_rsp_valid = 1'b0;
        total++;
        if (bus.err !== 1'b1 || bus.status[0].count !== '0 || bus.status[1].count !== '0) begin
            bad++; $display("FAIL bad_id got err=%b c0=%0d c1=%0d want err=1 c0=0 c1=0", bus.err, bus.status[0].count, bus.status[1].count);
        end
        bus.req_valid      = 2'b01;
        bus.req_control[0] = mk_ctl(e_REQUEST_READ, 0, 16'h0400);
        repeat (2) tick();
        total++;
        if (bus.status[0].count !== t_request_count'(2)) begin bad++; $display("FAIL stop_pre_count got=%0d want=2", bus.status[0].count); end
        bus.enable = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL stop_ready got=%b want=00", bus.req_ready); end
        tick();
        total++;
        if (bus.grant_valid !== 1'b0 || bus.idle !== 1'b0) begin
            bad++; $display("FAIL stop_drain_start got valid=%b idle=%b want valid=0 idle=0", bus.grant_valid, bus.idle);
        end
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_id    = 4'd0;
        tick();
        total++;
        if (bus.idle !== 1'b0 || bus.status[0].count !== t_request_count'(1)) begin
            bad++; $display("FAIL stop_one_left got idle=%b count=%0d want idle=0 count=1", bus.idle, bus.status[0].count);
        end
        tick();
        bus.rd_rsp_valid = 1'b0;
        total++;
        if (bus.idle !== 1'b1 || bus.status[0].empty !== 1'b1 || bus.grant_valid !== 1'b0) begin
            bad++; $display("FAIL stop_idle got idle=%b empty=%b valid=%b want 1 1 0", bus.idle, bus.status[0].empty, bus.grant_valid);
        end
        total++;
        if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            bus.enable     = ($urandom_range(0, 9) != 0);
            bus.tx_almfull = ($urandom_range(0, 4) == 0);
            bus.req_valid  = N'($urandom_range(0, (1 << N) - 1));
            for (int p = 0; p < N; p++)
                bus.req_control[p] = mk_ctl(t_request_cmd'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 16'hffff));
            bus.rd_rsp_valid = ($urandom_range(0, 2) == 0);
            bus.rd_rsp_id    = ($urandom_range(0, 31) == 0) ? t_request_cmd_id'($urandom_range(N, 15)) : t_request_cmd_id'($urandom_range(0, N - 1));
            bus.wr_rsp_valid = ($urandom_range(0, 3) == 0);
            bus.wr_rsp_id    = ($urandom_range(0, 31) == 0) ? t_request_cmd_id'($urandom_range(N, 15)) : t_request_cmd_id'($urandom_range(0, N - 1));
            #1;
            total++;
            if (bus.req_ready !== model_ready()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, bus.req_ready, model_ready()); end
            tick();
            total++;
            if (bus.grant_valid !== m_gv || bus.grant_control !== m_gc) begin
                bad++; $display("FAIL rnd_grant[%0d] got v=%b c=%h want v=%b c=%h", c, bus.grant_valid, bus.grant_control, m_gv, m_gc);
            end
            for (int p = 0; p < N; p++) begin
                total++;
                if (bus.status[p] !== model_status(p)) begin bad++; $display("FAIL rnd_status[%0d][%0d] got=%h want=%h", c, p, bus.status[p], model_status(p)); end
            end
            total++;
            if (bus.err !== m_err || bus.idle !== model_idle()) begin
                bad++; $display("FAIL rnd_err_idle[%0d] got err=%b idle=%b want err=%b idle=%b", c, bus.err, bus.idle, m_err, model_idle());
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_depth_limit();
        test_backpressure();
        test_simultaneous();
        test_errors_stop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hc_request_arbiter.md
Name: hc_request_arbiter

Overview:
- Shares the single CCI-P request path between NUM_PORTS buffer requesters, one per HardCloud TX/RX buffer.
- Each requester presents a t_request_control (cmd/id/offset). The arbiter grants round-robin, one request per cycle, and holds off when the CCI-P TX channel is almost full.
- Tracks outstanding (unresponded) requests per port against DEPTH and reports per-port t_request_status back to the requesters.
- Sits between the buffer request logic and the read/write requestor FSMs.

Parameters:
- NUM_PORTS, HC_BUFFER_SIZE (2): number of requesters.
- DEPTH, HC_REQUEST_DEPTH (8): maximum outstanding requests per port.

Ports:
- clk  in  1  CCI-P clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  high between HC_CONTROL_START and HC_CONTROL_STOP. Low blocks new grants.
- req_valid  in  NUM_PORTS  request pending, per port.
- req_control  in  NUM_PORTS x $bits(t_request_control)  packed per-port request.
- req_ready  out  NUM_PORTS  one-hot accept, combinational, same cycle.
- tx_almfull  in  1  CCI-P c0/c1 TX almost-full, OR-ed upstream.
- grant_valid  out  1  registered issued-request strobe.
- grant_control  out  $bits(t_request_control)  registered issued request.
- rd_rsp_valid  in  1  read completion.
- rd_rsp_id  in  $bits(t_request_cmd_id)  port of the read completion.
- wr_rsp_valid  in  1  write completion.
- wr_rsp_id  in  $bits(t_request_cmd_id)  port of the write completion.
- status  out  NUM_PORTS x $bits(t_request_status)  per-port empty/full/count.
- idle  out  1  enable low and all counts zero.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, reset_n=0): grant_valid=0, grant_control=0, all counts=0, rr_ptr=0, err=0.
  - status per port = {empty=1, full=0, count=0}.
  - idle=1 provided enable=0.
  - req_ready=0 while reset is asserted.
- Eligibility: port i is eligible when req_valid[i] & cmd != e_REQUEST_IDLE & count[i] < DEPTH & enable & !tx_almfull.
- Arbitration:
  - Among eligible ports, pick the first at or after rr_ptr, scanning upward modulo NUM_PORTS.
  - req_ready[i]=1 for the winner only, in the same cycle.
  - Next edge: grant_valid=1 and grant_control = the winner's req_control, with the id field forced to i.
  - rr_ptr becomes (i+1) mod NUM_PORTS.
  - With no winner: grant_valid=0, grant_control holds, rr_ptr holds.
- Grant latency: 1 cycle from acceptance to grant_valid. Maximum throughput is 1 grant per cycle.
- tx_almfull: sampled combinationally. When it is high, no req_ready is asserted in that cycle. A request already registered in grant_* still issues.
- Counters (width $clog2(DEPTH)+1, must fit t_request_size):
  - Each cycle: count[i] += grant_to_i − (rd_rsp_valid & rd_rsp_id==i) − (wr_rsp_valid & wr_rsp_id==i).
  - Grant and response to the same port in the same cycle: net 0.
  - rd and wr responses to the same port in the same cycle: −2.
  - grant_to_i is the acceptance cycle, not the registered grant cycle.
- Underflow: a decrement that would take count below 0 saturates at 0 and sets err.
- Bad id: a response id >= NUM_PORTS is ignored and sets err.
- err clears only on reset.
- Status: empty = (count==0), full = (count==DEPTH), count = count. Driven from registers.
- Stop: enable falling mid-stream stops new acceptance from that cycle on. Outstanding requests drain via responses.
- idle = !enable & all empty (registered-count based).
- Requester rule: once req_valid is asserted it must hold stable until req_ready. The arbiter does not check this.

Decomposition:
- Additions to hc_pkg:
  - t_request_count = logic [$clog2(HC_REQUEST_DEPTH):0].
  - t_arb_ptr = logic [$clog2(HC_BUFFER_SIZE)-1:0].
  - Function hc_rr_pick(valid vector, ptr) returning a one-hot vector.
- One sub-module: hc_outstanding_counter (per-port up/down saturating counter plus status/err outputs), instantiated NUM_PORTS times.

Test Plan:
- Reset then idle: assert and release reset_n with enable=0 -> status={1,0,0} on all ports, idle=1, grant_valid=0, err=0.
- Round-robin: enable=1, ports 0 and 1 valid continuously with READ_STREAM, offsets 0x10/0x20 -> grants alternate 0,1,0,1. grant_control.id matches the port, grant_valid=1 every cycle.
- Depth limit: port 0 only, no responses -> exactly 8 grants, then req_ready[0]=0 and status.full=1. One rd_rsp id=0 -> a 9th grant follows.
- Backpressure: tx_almfull=1 for 5 cycles with both ports valid -> no req_ready, grant_valid=0 from the second cycle on. Release -> grants resume at the rr_ptr port.
- Simultaneous events: count[1]=3, then in one cycle a grant to port 1 plus rd_rsp id=1 plus wr_rsp id=1 -> count[1]=2.
- Errors and stop:
  - wr_rsp id=0 while count[0]=0 -> count stays 0, err=1.
  - rd_rsp id=3 -> ignored, err stays 1.
  - Drop enable with 2 outstanding -> no new grants; idle=1 after 2 responses.
